// File: rtl/volt_stats_pkg.sv
// Shared definitions for the voltage statistics block: the controller state
// encoding used by volt_stats.
package volt_stats_pkg;

  localparam logic [2:0] IN_WAIT = 3'd0;
  localparam logic [2:0] IN_ACK  = 3'd1;
  localparam logic [2:0] OUT_SET = 3'd2;
  localparam logic [2:0] OUT_VAL = 3'd3;
  localparam logic [2:0] OUT_ACK = 3'd4;

  typedef enum logic [2:0] {
    S_IN_WAIT = IN_WAIT,
    S_IN_ACK  = IN_ACK,
    S_OUT_SET = OUT_SET,
    S_OUT_VAL = OUT_VAL,
    S_OUT_ACK = OUT_ACK
  } state_t;

endpackage

// File: rtl/volt_stats_acc.sv
// Group accumulator: running sum, minimum and maximum of the samples captured
// since the last group start.
module volt_stats_acc #(
  parameter int W      = 8,
  parameter int N_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                load,
  input  logic                first,
  input  logic                clear,
  input  logic [W-1:0]        x,
  output logic [W+N_LOG2-1:0] sum,
  output logic [W-1:0]        min,
  output logic [W-1:0]        max
);

  logic [W+N_LOG2-1:0] x_ext;

  assign x_ext = {{N_LOG2{1'b0}}, x};

  // The first sample of a group overwrites all three accumulators, so a stale
  // min/max from the previous group never leaks into the next one.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sum <= '0;
      min <= '0;
      max <= '0;
    end else if (load) begin
      sum <= first ? x_ext : sum + x_ext;
      min <= (first || (x < min)) ? x : min;
      max <= (first || (x > max)) ? x : max;
    end else if (clear) begin
      sum <= '0;
    end
  end

endmodule

// File: rtl/volt_stats.sv
// Voltage statistics stage: collects groups of 2**N_LOG2 samples over a
// dav_/rfd handshake and publishes min, max and truncated mean downstream.
module volt_stats
  import volt_stats_pkg::*;
#(
  parameter int W      = 8,
  parameter int N_LOG2 = 3
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav_in_,
  output logic         rfd_in,
  input  logic [W-1:0] x_in,
  output logic         dav_out_,
  input  logic         rfd_out,
  output logic [W-1:0] min_out,
  output logic [W-1:0] max_out,
  output logic [W-1:0] mean_out
);

  localparam logic [N_LOG2-1:0] LAST = '1;

  state_t              state, state_nxt;
  logic [N_LOG2-1:0]   count, count_nxt;
  logic                rfd_nxt, dav_nxt;
  logic                load, first, clear, publish;
  logic [W+N_LOG2-1:0] acc_sum;
  logic [W-1:0]        acc_min, acc_max;

  function automatic logic [W-1:0] trunc_mean(input logic [W+N_LOG2-1:0] s);
    return W'(s >> N_LOG2);
  endfunction

  volt_stats_acc #(.W(W), .N_LOG2(N_LOG2)) u_acc (
    .clock  (clock),
    .reset_ (reset_),
    .load   (load),
    .first  (first),
    .clear  (clear),
    .x      (x_in),
    .sum    (acc_sum),
    .min    (acc_min),
    .max    (acc_max)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rfd_nxt   = rfd_in;
    dav_nxt   = dav_out_;
    load      = 1'b0;
    first     = 1'b0;
    clear     = 1'b0;
    publish   = 1'b0;
    case (state)
      S_IN_WAIT: begin
        if (!dav_in_) begin
          load      = 1'b1;
          first     = (count == '0);
          rfd_nxt   = 1'b0;
          state_nxt = S_IN_ACK;
        end
      end
      S_IN_ACK: begin
        // rfd_in stays low after the last sample so upstream is held off
        // until the result has been taken downstream.
        if (dav_in_) begin
          if (count == LAST) begin
            state_nxt = S_OUT_SET;
          end else begin
            count_nxt = count + 1'b1;
            rfd_nxt   = 1'b1;
            state_nxt = S_IN_WAIT;
          end
        end
      end
      S_OUT_SET: begin
        publish   = 1'b1;
        clear     = 1'b1;
        count_nxt = '0;
        state_nxt = S_OUT_VAL;
      end
      S_OUT_VAL: begin
        if (rfd_out) begin
          dav_nxt   = 1'b0;
          state_nxt = S_OUT_ACK;
        end
      end
      S_OUT_ACK: begin
        if (!rfd_out) begin
          dav_nxt   = 1'b1;
          rfd_nxt   = 1'b1;
          state_nxt = S_IN_WAIT;
        end
      end
      default: state_nxt = S_IN_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= S_IN_WAIT;
      count    <= '0;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
      min_out  <= '0;
      max_out  <= '0;
      mean_out <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      rfd_in   <= rfd_nxt;
      dav_out_ <= dav_nxt;
      if (publish) begin
        min_out  <= acc_min;
        max_out  <= acc_max;
        mean_out <= trunc_mean(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_volt_stats.sv
// Bench for volt_stats: directed vector table, handshake corner sequences and
// random groups checked against a plain min/max/average model.
module tb_volt_stats;
  localparam int W      = 8;
  localparam int N_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;
  localparam int BOUND  = 500;

  typedef logic [N-1:0][W-1:0] grp_t;
  typedef struct {
    grp_t       s;
    logic [7:0] emin;
    logic [7:0] emax;
    logic [7:0] emean;
  } vec_t;

  logic         clock   = 1'b0;
  logic         reset_  = 1'b0;
  logic         dav_in_ = 1'b1;
  logic         rfd_out = 1'b0;
  logic [W-1:0] x_in    = '0;
  logic         rfd_in, dav_out_;
  logic [W-1:0] min_out, max_out, mean_out;

  int checks   = 0;
  int failures = 0;
  int falls    = 0;
  logic dav_prev = 1'b1;

  volt_stats #(.W(W), .N_LOG2(N_LOG2)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .x_in     (x_in),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out),
    .min_out  (min_out),
    .max_out  (max_out),
    .mean_out (mean_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (dav_prev === 1'b1 && dav_out_ === 1'b0) falls++;
    dav_prev = dav_out_;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // which: 0 = rfd_in, 1 = dav_out_
  task automatic wait_sig(input int which, input logic val, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clock);
      if ((which == 0 ? rfd_in : dav_out_) === val) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=timeout required=%0d", name, val);
  endtask

  task automatic send_sample(input logic [W-1:0] v, input int gap);
    bit ok;
    repeat (gap) @(negedge clock);
    wait_sig(0, 1'b1, "rfd_in_high", ok);
    if (!ok) return;
    x_in    = v;
    dav_in_ = 1'b0;
    wait_sig(0, 1'b0, "rfd_in_low", ok);
    dav_in_ = 1'b1;
  endtask

  task automatic get_result(output logic [W-1:0] mn, output logic [W-1:0] mx,
                            output logic [W-1:0] me);
    bit ok;
    rfd_out = 1'b1;
    wait_sig(1, 1'b0, "dav_out_low", ok);
    mn = min_out;
    mx = max_out;
    me = mean_out;
    rfd_out = 1'b0;
    wait_sig(1, 1'b1, "dav_out_high", ok);
  endtask

  function automatic void model(input grp_t g, output logic [7:0] mn,
                                output logic [7:0] mx, output logic [7:0] me);
    int lo, hi, total;
    lo = 256; hi = -1; total = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(g[i]) < lo) lo = int'(g[i]);
      if (int'(g[i]) > hi) hi = int'(g[i]);
      total += int'(g[i]);
    end
    mn = 8'(lo);
    mx = 8'(hi);
    me = 8'(total / N);
  endfunction

  task automatic run_group(input grp_t g, input logic [7:0] emn, input logic [7:0] emx,
                           input logic [7:0] eme, input string tag, input bit gaps);
    logic [W-1:0] mn, mx, me;
    for (int i = 0; i < N; i++)
      send_sample(g[i], gaps ? int'($urandom_range(0, 3)) : 0);
    get_result(mn, mx, me);
    chk($sformatf("%s_min", tag), 32'(mn), 32'(emn));
    chk($sformatf("%s_max", tag), 32'(mx), 32'(emx));
    chk($sformatf("%s_mean", tag), 32'(me), 32'(eme));
  endtask

  vec_t tbl[5];

  initial begin
    logic [7:0] mn, mx, me, rmn, rmx, rme;
    grp_t g;
    int bad_dav, bad_rfd;
    bit ok;

    tbl[0].s = grp_t'({8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    tbl[0].emin = 8'd10;  tbl[0].emax = 8'd80;  tbl[0].emean = 8'd45;
    tbl[1].s = grp_t'({8{8'd255}});
    tbl[1].emin = 8'd255; tbl[1].emax = 8'd255; tbl[1].emean = 8'd255;
    tbl[2].s = grp_t'({8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0});
    tbl[2].emin = 8'd0;   tbl[2].emax = 8'd1;   tbl[2].emean = 8'd0;
    tbl[3].s = grp_t'({8{8'd77}});
    tbl[3].emin = 8'd77;  tbl[3].emax = 8'd77;  tbl[3].emean = 8'd77;
    tbl[4].s = grp_t'({8'd9, 8'd1, 8'd250, 8'd100, 8'd3, 8'd3, 8'd200, 8'd7});
    tbl[4].emin = 8'd1;   tbl[4].emax = 8'd250; tbl[4].emean = 8'd71;

    repeat (3) @(negedge clock);
    chk("reset_rfd_in", 32'(rfd_in), 32'd1);
    chk("reset_dav_out", 32'(dav_out_), 32'd1);
    chk("reset_min", 32'(min_out), 32'd0);
    chk("reset_max", 32'(max_out), 32'd0);
    chk("reset_mean", 32'(mean_out), 32'd0);
    reset_ = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      run_group(tbl[v].s, tbl[v].emin, tbl[v].emax, tbl[v].emean, $sformatf("vec%0d", v), 1'b0);
      if (v == 0) chk("vec0_dav_falls", 32'(falls), 32'd1);
    end

    // Downstream stalls; a waiting upstream sample must not be taken until
    // the result has been handed over.
    g = tbl[0].s;
    for (int i = 0; i < N; i++) send_sample(g[i], 0);
    @(negedge clock);
    x_in = 8'd99;
    dav_in_ = 1'b0;
    bad_dav = 0;
    bad_rfd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (dav_out_ !== 1'b1) bad_dav++;
      if (rfd_in !== 1'b0) bad_rfd++;
    end
    chk("hold_dav_out_high", 32'(bad_dav), 32'd0);
    chk("hold_rfd_in_low", 32'(bad_rfd), 32'd0);
    get_result(mn, mx, me);
    chk("hold_min", 32'(mn), 32'd10);
    chk("hold_max", 32'(mx), 32'd80);
    chk("hold_mean", 32'(me), 32'd45);
    wait_sig(0, 1'b0, "held_capture", ok);
    dav_in_ = 1'b1;
    g[0] = 8'd99;
    for (int i = 1; i < N; i++) begin
      g[i] = 8'(i * 3);
      send_sample(g[i], 1);
    end
    model(g, rmn, rmx, rme);
    get_result(mn, mx, me);
    chk("held_min", 32'(mn), 32'(rmn));
    chk("held_max", 32'(mx), 32'(rmx));
    chk("held_mean", 32'(me), 32'(rme));

    // Reset part-way through a group discards it.
    for (int i = 0; i < 5; i++) send_sample(8'd200, 0);
    @(negedge clock);
    reset_ = 1'b0;
    #1;
    chk("midgrp_rst_rfd_in", 32'(rfd_in), 32'd1);
    chk("midgrp_rst_dav_out", 32'(dav_out_), 32'd1);
    chk("midgrp_rst_max", 32'(max_out), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    run_group(tbl[0].s, 8'd10, 8'd80, 8'd45, "fresh", 1'b0);

    // Reset while a result is being offered.
    for (int i = 0; i < N; i++) send_sample(8'd50, 0);
    rfd_out = 1'b1;
    wait_sig(1, 1'b0, "midout_dav", ok);
    reset_ = 1'b0;
    #1;
    chk("midout_rst_dav_out", 32'(dav_out_), 32'd1);
    chk("midout_rst_mean", 32'(mean_out), 32'd0);
    rfd_out = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    run_group(tbl[4].s, 8'd1, 8'd250, 8'd71, "after_rst", 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) g[i] = 8'($urandom_range(0, 255));
      model(g, rmn, rmx, rme);
      run_group(g, rmn, rmx, rme, $sformatf("rand%0d", r), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
